mem_arbiter: RTL and testbench

Two-requester arbiter sharing one multi-cycle memory port between instruction fetch and load/store. It sits between the core's fetch and data-access logic and a single shared memory that has a req/ack handshake. The block latches the winning request, holds it stable on the memory port until acknowledged, and returns read data with a one-cycle done pulse. Grants are round-robin. A watchdog aborts transactions the memory never acknowledges.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one req/ack memory port between instruction fetch and load/store.
// The winning request is latched for the whole transaction; a watchdog aborts unacknowledged accesses.
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_done,
    output logic [WIDTH-1:0] if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_done,
    output logic [WIDTH-1:0] d_rdata,
    output logic             err,
    output logic             busy,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_gnt;   // 0 = fetch, 1 = data
    logic             owner;      // 0 = fetch, 1 = data
    logic             lat_we;
    logic [WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0] lat_wdata;

    logic             grant_any;
    logic             grant_d;
    logic             finish;
    logic             timed_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_any = 1'b0;
        grant_d   = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_any = 1'b1;
                    // On a tie the side not granted last time wins
                    grant_d   = d_req && (!if_req || !last_gnt);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    finish    = 1'b1;
                    state_nxt = RESP;
                end else if (cnt == CNT_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            last_gnt  <= 1'b0;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_done <= finish && !owner;
            d_done  <= finish && owner;
            err     <= timed_out;
            if (grant_any) begin
                owner     <= grant_d;
                last_gnt  <= grant_d;
                lat_we    <= grant_d && d_we;
                lat_addr  <= grant_d ? d_addr : if_addr;
                lat_wdata <= grant_d ? d_wdata : '0;
                cnt       <= '0;
            end else if (state == BUSY && !finish) begin
                cnt <= cnt + CNT_ONE;
            end
            // Stores capture mem_rdata too; an aborted access returns zero
            if (finish) begin
                if (owner) begin
                    d_rdata <= mem_ack ? mem_rdata : '0;
                end else begin
                    if_rdata <= mem_ack ? mem_rdata : '0;
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign mem_req   = (state == BUSY);
    assign mem_we    = lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT = 4: fetch, store, tie, watchdog, async reset, stale request.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests_run = 0;
    int tests_failed = 0;
    bit own_d;

    mem_arbiter #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .err(err), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chkb({tag, ".mem_req"}, mem_req, 1'b0);
        chkb({tag, ".busy"}, busy, 1'b0);
        chkb({tag, ".if_done"}, if_done, 1'b0);
        chkb({tag, ".d_done"}, d_done, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        tick(); tick();
        chk_idle_outputs("rst");
        chkb("rst.mem_we", mem_we, 1'b0);
        chkb("rst.err", err, 1'b0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        chk("rst.if_rdata", if_rdata, 32'h0);
        chk("rst.d_rdata", d_rdata, 32'h0);
        rst = 1'b1;
        tick();

        // Single fetch, ack in third BUSY cycle
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chkb("fetch.mem_req", mem_req, 1'b1);
            chkb("fetch.busy", busy, 1'b1);
            chk("fetch.mem_addr", mem_addr, 32'h100);
            chkb("fetch.mem_we", mem_we, 1'b0);
            chkb("fetch.d_done", d_done, 1'b0);
            chkb("fetch.if_done_early", if_done, 1'b0);
        end
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'hFFFFFFFF;
        chkb("fetch.if_done", if_done, 1'b1);
        chk("fetch.if_rdata", if_rdata, 32'h00500093);
        chkb("fetch.err", err, 1'b0);
        chkb("fetch.d_done_resp", d_done, 1'b0);
        chkb("fetch.mem_req_resp", mem_req, 1'b0);
        chkb("fetch.busy_resp", busy, 1'b1);
        if_req = 1'b0;
        tick();
        chk_idle_outputs("fetch.after");
        chk("fetch.if_rdata_hold", if_rdata, 32'h00500093);

        // Store with address change mid-BUSY
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chkb("store.mem_req", mem_req, 1'b1);
            chk("store.mem_addr", mem_addr, 32'h2000);
            chk("store.mem_wdata", mem_wdata, 32'hDEADBEEF);
            chkb("store.mem_we", mem_we, 1'b1);
            d_addr = 32'h0; d_wdata = 32'h0;
        end
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        chkb("store.d_done", d_done, 1'b1);
        chkb("store.if_done", if_done, 1'b0);
        chkb("store.err", err, 1'b0);
        chk("store.d_rdata", d_rdata, 32'h12345678);
        chk("store.if_rdata_hold", if_rdata, 32'h00500093);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk_idle_outputs("store.after");

        // Tie after reset: data, fetch, data, fetch
        rst = 1'b0;
        tick();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'hA0;
        d_req = 1'b1; d_addr = 32'hB0; d_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            own_d = (i % 2 == 0);
            tick();
            chkb("tie.mem_req", mem_req, 1'b1);
            chk("tie.mem_addr", mem_addr, own_d ? 32'hB0 : 32'hA0);
            mem_ack = 1'b1; mem_rdata = 32'h1000 + 32'(i);
            tick();
            mem_ack = 1'b0;
            chkb("tie.d_done", d_done, own_d);
            chkb("tie.if_done", if_done, !own_d);
            if (own_d) chk("tie.d_rdata", d_rdata, 32'h1000 + 32'(i));
            else       chk("tie.if_rdata", if_rdata, 32'h1000 + 32'(i));
            tick();
            chkb("tie.idle_busy", busy, 1'b0);
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();
        chk_idle_outputs("tie.after");

        // Watchdog abort with no ack
        d_req = 1'b1; d_addr = 32'h300;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chkb("tmo.mem_req", mem_req, 1'b1);
            chkb("tmo.d_done_early", d_done, 1'b0);
        end
        tick();
        chkb("tmo.d_done", d_done, 1'b1);
        chkb("tmo.err", err, 1'b1);
        chk("tmo.d_rdata", d_rdata, 32'h0);
        chkb("tmo.mem_req_resp", mem_req, 1'b0);
        d_req = 1'b0;
        tick();
        chk_idle_outputs("tmo.after");
        chkb("tmo.err_clear", err, 1'b0);

        // Ack in the last watchdog cycle wins
        d_req = 1'b1; d_addr = 32'h304;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chkb("tmo_ack.mem_req", mem_req, 1'b1);
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        chkb("tmo_ack.d_done", d_done, 1'b1);
        chkb("tmo_ack.err", err, 1'b0);
        chk("tmo_ack.d_rdata", d_rdata, 32'hCAFEF00D);
        d_req = 1'b0;
        tick();
        chk_idle_outputs("tmo_ack.after");

        // Asynchronous reset mid-BUSY
        if_req = 1'b1; if_addr = 32'h400;
        tick();
        chkb("arst.mem_req_before", mem_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_idle_outputs("arst.now");
        chk("arst.mem_addr", mem_addr, 32'h0);
        chk("arst.d_rdata", d_rdata, 32'h0);
        chk("arst.if_rdata", if_rdata, 32'h0);
        chkb("arst.err", err, 1'b0);
        if_req = 1'b0;
        tick();
        chk_idle_outputs("arst.held");
        rst = 1'b1;
        tick();
        chk_idle_outputs("arst.released");
        if_req = 1'b1; if_addr = 32'h500;
        tick();
        chk("arst.fresh_addr", mem_addr, 32'h500);
        mem_ack = 1'b1; mem_rdata = 32'h11;
        tick();
        mem_ack = 1'b0;
        chkb("arst.fresh_done", if_done, 1'b1);
        chk("arst.fresh_rdata", if_rdata, 32'h11);
        if_req = 1'b0;
        tick();

        // Stale request held through RESP becomes a new grant
        if_req = 1'b1; if_addr = 32'h600;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h22;
        tick();
        mem_ack = 1'b0;
        chkb("stale.done1", if_done, 1'b1);
        chk("stale.rdata1", if_rdata, 32'h22);
        tick();
        chkb("stale.idle", busy, 1'b0);
        tick();
        chkb("stale.regrant", mem_req, 1'b1);
        chk("stale.regrant_addr", mem_addr, 32'h600);
        mem_ack = 1'b1; mem_rdata = 32'h33;
        tick();
        mem_ack = 1'b0;
        chkb("stale.done2", if_done, 1'b1);
        chk("stale.rdata2", if_rdata, 32'h33);
        if_req = 1'b0;
        tick();
        chk_idle_outputs("stale.dropped_idle");
        tick();
        chk_idle_outputs("stale.no_regrant");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
